nanorv32_uart_ctrl: RTL and testbench

- Peripheral-bus responder: a UART (8N1) with a TX FIFO and a single-entry RX holding register, register-mapped behind nanorv32_periph_mux alongside nanorv32_gpio_ctrl.
- Answers the mux-side request protocol (addr/bytesel/din/en in, dout/ready_nxt out) and drives/samples one serial pad pair at chip top.

---
 rtl/nanorv32_uart_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_nanorv32_uart_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nanorv32_uart_ctrl.sv
// 8N1 UART peripheral: TX FIFO, single-entry RX holding register and a
// four-word register file (DATA/STATUS/DIVISOR/CTRL) behind the peripheral mux.
module nanorv32_uart_ctrl #(
    parameter int          TX_FIFO_DEPTH            = 4,
    parameter logic [15:0] DEFAULT_DIV              = 16'd868,
    parameter int          NANORV32_PERIPH_ADDR_MSB = 7
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NANORV32_PERIPH_ADDR_MSB:0]   bus_uart_addr,
    input  logic [3:0]                          bus_uart_bytesel,
    input  logic [31:0]                         bus_uart_din,
    input  logic                                bus_uart_en,
    output logic [31:0]                         uart_bus_dout,
    output logic                                uart_bus_ready_nxt,
    input  logic                                pad_uart_rx,
    output logic                                uart_pad_tx,
    output logic                                uart_irq
);
    localparam int PW = $clog2(TX_FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(TX_FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

    logic [15:0] divisor;
    logic [2:0]  ctrl;
    logic        rx_valid, rx_overrun, rx_frame_err, tx_ovf;
    logic [7:0]  rx_byte;

    // Bus decode
    logic [1:0] sel;
    logic       bus_wr, bus_rd, wr_data, rd_data, w1c, div_wr;
    logic [15:0] div_new;
    logic        unused_bits;

    assign uart_bus_ready_nxt = bus_uart_en;
    assign sel     = bus_uart_addr[3:2];
    assign bus_wr  = bus_uart_en & (|bus_uart_bytesel);
    assign bus_rd  = bus_uart_en & ~(|bus_uart_bytesel);
    assign wr_data = bus_wr & (sel == 2'd0) & bus_uart_bytesel[0];
    assign rd_data = bus_rd & (sel == 2'd0);
    assign w1c     = bus_wr & (sel == 2'd1) & bus_uart_bytesel[0];
    assign div_wr  = bus_wr & (sel == 2'd2) & (|bus_uart_bytesel[1:0]);
    assign div_new = {bus_uart_bytesel[1] ? bus_uart_din[15:8] : divisor[15:8],
                      bus_uart_bytesel[0] ? bus_uart_din[7:0]  : divisor[7:0]};
    assign unused_bits = ^{bus_uart_addr[NANORV32_PERIPH_ADDR_MSB:4], bus_uart_addr[1:0],
                           bus_uart_din[31:16]};

    // TX FIFO
    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    logic          fifo_full, fifo_empty, tx_pop, push_ok;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    // A pop in the same cycle frees the slot a push on a full FIFO needs.
    assign push_ok    = wr_data & (~fifo_full | tx_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wptr] <= bus_uart_din[7:0];
                wptr           <= wptr + PW'(1);
            end
            if (tx_pop) rptr <= rptr + PW'(1);
            case ({push_ok, tx_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // TX state machine
    uart_st_e    tx_st, tx_nxt;
    logic [15:0] tx_cnt, tx_div;
    logic [7:0]  tx_sh;
    logic [2:0]  tx_bit;
    logic        tx_done, tx_line;

    assign tx_done = (tx_cnt == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_st <= S_IDLE;
        else     tx_st <= tx_nxt;
    end

    always_comb begin
        tx_nxt = tx_st;
        case (tx_st)
            S_IDLE:  if (ctrl[0] && !fifo_empty) tx_nxt = S_START;
            S_START: if (tx_done) tx_nxt = S_DATA;
            S_DATA:  if (tx_done && tx_bit == 3'd7) tx_nxt = S_STOP;
            S_STOP:  if (tx_done) tx_nxt = (ctrl[0] && !fifo_empty) ? S_START : S_IDLE;
            default: tx_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_pop  = (tx_nxt == S_START) && (tx_st == S_IDLE || tx_st == S_STOP);
        tx_line = 1'b1;
        case (tx_st)
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_sh[0];
            default: tx_line = 1'b1;
        endcase
    end

    // Divisor is latched per frame so a mid-frame write waits for the next start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt      <= '0;
            tx_div      <= DEFAULT_DIV;
            tx_sh       <= '0;
            tx_bit      <= '0;
            uart_pad_tx <= 1'b1;
        end else begin
            uart_pad_tx <= tx_line;
            if (tx_pop) begin
                tx_sh  <= fifo_mem[rptr];
                tx_div <= divisor;
                tx_cnt <= divisor - 16'd1;
                tx_bit <= '0;
            end else if (tx_st != S_IDLE) begin
                if (tx_done) begin
                    tx_cnt <= tx_div - 16'd1;
                    if (tx_st == S_DATA) begin
                        tx_sh  <= tx_sh >> 1;
                        tx_bit <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    // RX synchronizer and state machine
    logic        rx_s1, rx_s2, rx_prev, rx_fall;
    uart_st_e    rx_st, rx_nxt;
    logic [15:0] rx_cnt, rx_div;
    logic [7:0]  rx_sh;
    logic [2:0]  rx_bit;
    logic        rx_done, rx_complete, rx_ferr;

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_done = (rx_cnt == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            rx_st   <= S_IDLE;
        end else begin
            rx_s1   <= pad_uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_st   <= rx_nxt;
        end
    end

    always_comb begin
        rx_nxt = rx_st;
        if (!ctrl[1]) rx_nxt = S_IDLE;
        else begin
            case (rx_st)
                S_IDLE:  if (rx_fall) rx_nxt = S_START;
                S_START: if (rx_done) rx_nxt = rx_s2 ? S_IDLE : S_DATA;
                S_DATA:  if (rx_done && rx_bit == 3'd7) rx_nxt = S_STOP;
                S_STOP:  if (rx_done) rx_nxt = S_IDLE;
                default: rx_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_complete = 1'b0;
        rx_ferr     = 1'b0;
        if (ctrl[1] && rx_st == S_STOP && rx_done) begin
            rx_complete = rx_s2;
            rx_ferr     = ~rx_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt <= '0;
            rx_div <= DEFAULT_DIV;
            rx_sh  <= '0;
            rx_bit <= '0;
        end else if (rx_st == S_IDLE) begin
            if (rx_nxt == S_START) begin
                rx_cnt <= {1'b0, divisor[15:1]} - 16'd1;
                rx_div <= divisor;
                rx_bit <= '0;
            end
        end else if (rx_done) begin
            rx_cnt <= rx_div - 16'd1;
            if (rx_st == S_DATA) begin
                rx_sh  <= {rx_s2, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt - 16'd1;
        end
    end

    // Register file; sticky flags give priority to a same-cycle set over a clear.
    logic [31:0] rd_mux;
    logic [6:0]  status;

    assign status   = {tx_ovf, rx_frame_err, tx_st != S_IDLE, rx_overrun, rx_valid,
                       fifo_empty && tx_st == S_IDLE, fifo_full};
    assign uart_irq = rx_valid | (status[1] & ctrl[2]);

    always_comb begin
        rd_mux = '0;
        case (sel)
            2'd0:    rd_mux = {24'b0, rx_byte};
            2'd1:    rd_mux = {25'b0, status};
            2'd2:    rd_mux = {16'b0, divisor};
            default: rd_mux = {29'b0, ctrl};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor       <= DEFAULT_DIV;
            ctrl          <= '0;
            rx_byte       <= '0;
            rx_valid      <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_frame_err  <= 1'b0;
            tx_ovf        <= 1'b0;
            uart_bus_dout <= '0;
        end else begin
            if (bus_rd) uart_bus_dout <= rd_mux;
            if (div_wr) divisor <= (div_new < 16'd4) ? 16'd4 : div_new;
            if (bus_wr && sel == 2'd3 && bus_uart_bytesel[0]) ctrl <= bus_uart_din[2:0];
            if (rx_complete && !(rx_valid && !rd_data)) begin
                rx_byte  <= rx_sh;
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
            rx_overrun   <= (rx_overrun & ~(w1c & bus_uart_din[3]))
                          | (rx_complete & rx_valid & ~rd_data);
            rx_frame_err <= (rx_frame_err & ~(w1c & bus_uart_din[5])) | rx_ferr;
            tx_ovf       <= (tx_ovf & ~(w1c & bus_uart_din[6])) | (wr_data & fifo_full & ~tx_pop);
        end
    end
endmodule

// File: tb/tb_nanorv32_uart_ctrl.sv
// Scoreboard bench for nanorv32_uart_ctrl: bus reads and decoded serial
// frames are checked by independent monitors against queued expectations.
module tb_nanorv32_uart_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic [3:0]  bs;
    logic [31:0] din;
    logic        en;
    logic [31:0] dout;
    logic        rdy;
    logic        rx_pad;
    logic        tx;
    logic        irq;

    nanorv32_uart_ctrl dut (
        .clk(clk), .rst(rst),
        .bus_uart_addr(addr), .bus_uart_bytesel(bs), .bus_uart_din(din), .bus_uart_en(en),
        .uart_bus_dout(dout), .uart_bus_ready_nxt(rdy),
        .pad_uart_rx(rx_pad), .uart_pad_tx(tx), .uart_irq(irq)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_q[$];
    string       rd_n[$];
    logic [7:0]  tx_exp[$];
    int          tx_div = 8;
    bit          b2b_chk = 0;
    longint      cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Read-data monitor: one queued expectation per accepted read.
    initial forever begin
        @(posedge clk);
        if (en && bs == 4'h0) begin
            #1;
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected actual=%h expected=none", dout);
            end else begin
                chk(rd_n.pop_front(), dout, rd_q.pop_front());
            end
        end
    end

    // Serial monitor: samples mid-bit using the divisor the bench configured.
    int         m_cnt, m_k;
    bit         m_act = 0, m_prev = 0;
    logic [7:0] m_byte;
    longint     m_last;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            m_act  = 0;
            m_prev = 0;
        end else if (!m_act) begin
            if (tx == 1'b0) begin
                m_act = 1; m_cnt = 0; m_k = 0;
                if (b2b_chk && m_prev) chk("tx_b2b_gap", 32'(cyc - m_last), 32'(10 * tx_div));
                m_prev = b2b_chk;
                m_last = cyc;
            end
        end else begin
            m_cnt++;
            if (m_cnt == tx_div / 2 + m_k * tx_div) begin
                if (m_k == 0) chk("tx_start_bit", 32'(tx), 32'd0);
                else if (m_k < 9) m_byte[m_k-1] = tx;
                else begin
                    chk("tx_stop_bit", 32'(tx), 32'd1);
                    if (tx_exp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_unexpected actual=%h expected=none", m_byte);
                    end else chk("tx_byte", 32'(m_byte), 32'(tx_exp.pop_front()));
                    m_act = 0;
                end
                m_k++;
            end
        end
    end

    task automatic bus_wr(input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
        addr = a; bs = b; din = d; en = 1'b1;
        #1 chk("ready_wr", 32'(rdy), 32'd1);
        @(negedge clk);
        en = 1'b0; bs = 4'h0;
    endtask

    task automatic bus_rd(input logic [7:0] a, input logic [31:0] e, input string n);
        rd_q.push_back(e); rd_n.push_back(n);
        addr = a; bs = 4'h0; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb, input int div);
        rx_pad = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pad = b[i];
            repeat (div) @(negedge clk);
        end
        rx_pad = stopb;
        repeat (div) @(negedge clk);
        rx_pad = 1'b1;
    endtask

    logic [7:0] b, b1, b2, b3;
    int         d;
    initial begin
        rst = 1'b1; en = 1'b0; bs = 4'h0; din = '0; addr = '0; rx_pad = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_dout", dout, 32'd0);
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset register values
        bus_rd(8'h8, 32'h364, "div_rst");
        bus_rd(8'h4, 32'h02, "status_rst");
        bus_rd(8'hC, 32'h0, "ctrl_rst");

        // Single 0xA5 frame at divisor 8
        bus_wr(8'h8, 4'h3, 32'd8);
        tx_div = 8;
        bus_wr(8'hC, 4'h1, 32'h1);
        tx_exp.push_back(8'hA5);
        bus_wr(8'h0, 4'h1, 32'hA5);
        repeat (5) @(negedge clk);
        bus_rd(8'h4, 32'h10, "status_busy");
        repeat (100) @(negedge clk);
        bus_rd(8'h4, 32'h02, "status_done");

        // Fill the FIFO with TX disabled, overflow, then drain back-to-back
        bus_wr(8'hC, 4'h1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            if (i < 4) tx_exp.push_back(b);
            bus_wr(8'h0, 4'h1, {24'h0, b});
            if (i == 3) bus_rd(8'h4, 32'h01, "status_full");
        end
        bus_rd(8'h4, 32'h41, "status_ovf");
        b2b_chk = 1;
        bus_wr(8'hC, 4'h1, 32'h1);
        repeat (4 * 80 + 30) @(negedge clk);
        b2b_chk = 0;
        bus_rd(8'h4, 32'h42, "status_ovf_idle");
        bus_wr(8'h4, 4'h1, 32'h40);
        bus_rd(8'h4, 32'h02, "status_ovf_clr");

        // TX empty interrupt
        bus_wr(8'hC, 4'h1, 32'h5);
        chk("irq_txie", 32'(irq), 32'd1);

        // Random TX bytes at random divisors
        for (int i = 0; i < 3; i++) begin
            d = int'($urandom_range(4, 12));
            bus_wr(8'h8, 4'h3, 32'(d));
            tx_div = d;
            bus_rd(8'h8, 32'(d), "div_rd");
            b = 8'($urandom);
            tx_exp.push_back(b);
            bus_wr(8'h0, 4'h1, {24'h0, b});
            repeat (10 * d + 20) @(negedge clk);
        end

        // RX single byte at divisor 16
        bus_wr(8'hC, 4'h1, 32'h2);
        bus_wr(8'h8, 4'h3, 32'd16);
        b = 8'h3C;
        fork
            send_rx(b, 1'b1, 16);
            begin
                repeat (9 * 16) @(negedge clk);
                chk("irq_early", 32'(irq), 32'd0);
            end
        join
        chk("irq_rx", 32'(irq), 32'd1);
        bus_rd(8'h4, 32'h06, "status_rxv");
        bus_rd(8'h0, {24'h0, b}, "rx_data");
        bus_rd(8'h4, 32'h02, "status_rx_clr");
        chk("irq_cleared", 32'(irq), 32'd0);

        // Overrun keeps the first byte
        b1 = 8'($urandom); b2 = 8'($urandom);
        send_rx(b1, 1'b1, 16);
        send_rx(b2, 1'b1, 16);
        repeat (2) @(negedge clk);
        bus_rd(8'h4, 32'h0E, "status_ovr");
        bus_rd(8'h0, {24'h0, b1}, "ovr_keep");
        bus_wr(8'h4, 4'h1, 32'h08);
        bus_rd(8'h4, 32'h02, "ovr_clr");

        // Short glitch is rejected
        rx_pad = 1'b0;
        repeat (3) @(negedge clk);
        rx_pad = 1'b1;
        repeat (40) @(negedge clk);
        bus_rd(8'h4, 32'h02, "glitch");

        // Framing error leaves the held byte alone
        b3 = 8'($urandom);
        send_rx(b3, 1'b1, 16);
        send_rx(8'($urandom), 1'b0, 16);
        repeat (2) @(negedge clk);
        bus_rd(8'h4, 32'h26, "status_ferr");
        bus_rd(8'h0, {24'h0, b3}, "ferr_keep");
        bus_wr(8'h4, 4'h1, 32'h20);
        bus_rd(8'h4, 32'h02, "ferr_clr");

        // Random RX bytes at random divisors
        for (int i = 0; i < 3; i++) begin
            d = int'($urandom_range(16, 40));
            bus_wr(8'h8, 4'h3, 32'(d));
            b = 8'($urandom);
            send_rx(b, 1'b1, d);
            repeat (2) @(negedge clk);
            bus_rd(8'h0, {24'h0, b}, "rx_rand");
        end

        // Reset in the middle of a TX frame of zeros
        bus_wr(8'hC, 4'h1, 32'h1);
        bus_wr(8'h8, 4'h3, 32'd8);
        tx_div = 8;
        tx_exp.push_back(8'h00);
        bus_wr(8'h0, 4'h1, 32'h0);
        repeat (30) @(negedge clk);
        chk("tx_mid_frame", 32'(tx), 32'd0);
        #2 rst = 1'b1;
        #1 chk("tx_rst_async", 32'(tx), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tx_exp.delete();
        bus_rd(8'h8, 32'h364, "div_rst2");
        bus_rd(8'h4, 32'h02, "status_rst2");
        bus_rd(8'hC, 32'h0, "ctrl_rst2");
        bus_wr(8'h8, 4'h3, 32'd1);
        bus_rd(8'h8, 32'd4, "div_min");

        repeat (20) @(negedge clk);
        chk("tx_exp_drained", 32'(tx_exp.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
